// File: rtl/uart_xmt_arbiter.sv
// UART transmit arbiter: grants one of NREQ byte requesters and steps the transmitter strobes.
// Define UART_XMT_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module uart_xmt_arbiter #(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 12
) (
  input  logic                    Clock,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [7:0]              Data_Bus,
  output logic                    Load_XMT_datareg,
  output logic                    Byte_ready,
  output logic                    T_byte
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, LOAD, READY, SEND, WAIT} state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [7:0]     byte_reg;
  logic [IDW-1:0] start;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           win_found;

`ifdef UART_XMT_ARB_RR_EN
  logic [IDW-1:0] ptr;

  // Pointer moves to the slot after the winner so the winner gets lowest priority next time.
  always_ff @(posedge Clock or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (state == IDLE && win_found)
      ptr <= (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(start) + i) % NREQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Outputs are set on entry to the state in which they must be visible.
  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      byte_reg         <= '0;
      ack              <= '0;
      grant_id         <= '0;
      busy             <= 1'b0;
      Data_Bus         <= '0;
      Load_XMT_datareg <= 1'b0;
      Byte_ready       <= 1'b0;
      T_byte           <= 1'b0;
    end else begin
      ack              <= '0;
      Load_XMT_datareg <= 1'b0;
      Byte_ready       <= 1'b0;
      T_byte           <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            byte_reg         <= req_data[{win_id, 3'b000} +: 8];
            Data_Bus         <= req_data[{win_id, 3'b000} +: 8];
            grant_id         <= win_id;
            busy             <= 1'b1;
            ack              <= NREQ'(1) << win_id;
            Load_XMT_datareg <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          Data_Bus   <= byte_reg;
          Byte_ready <= 1'b1;
          state      <= READY;
        end
        READY: begin
          Data_Bus <= byte_reg;
          T_byte   <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          Data_Bus <= '0;
          cnt      <= 8'(FRAME_CYCLES - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_xmt_arbiter.sv
// Self-checking bench for uart_xmt_arbiter: phase-based reference model plus directed literal checks.
// Honours UART_XMT_ARB_RR_EN the same way as the design.
module tb_uart_xmt_arbiter;
  localparam int NREQ = 4;
  localparam int F    = 12;
  localparam int IDW  = $clog2(NREQ);

  logic              Clock;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic [7:0]        Data_Bus;
  logic              Load_XMT_datareg;
  logic              Byte_ready;
  logic              T_byte;

  int n_cmp = 0;
  int n_bad = 0;

  uart_xmt_arbiter #(.NREQ(NREQ), .FRAME_CYCLES(F)) dut (
    .Clock(Clock), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .Data_Bus(Data_Bus),
    .Load_XMT_datareg(Load_XMT_datareg), .Byte_ready(Byte_ready), .T_byte(T_byte)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference model: a frame is described by its phase since the grant edge.
  // Phase 1 = load, 2 = ready, 3 = send, 4..F+3 = wait window, F+4 = back to idle.
  bit         m_active = 1'b0;
  int         m_phase  = 0;
  int         m_id     = 0;
  int         m_ptr    = 0;
  logic [7:0] m_byte   = 8'h00;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  always @(posedge Clock or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_phase  = 0;
      m_id     = 0;
      m_ptr    = 0;
      m_byte   = 8'h00;
    end else if (!m_active) begin
      if (req != '0) begin
        m_id     = pick(req, m_ptr);
        m_byte   = req_data[8*m_id +: 8];
        m_active = 1'b1;
        m_phase  = 1;
`ifdef UART_XMT_ARB_RR_EN
        m_ptr    = (m_id + 1) % NREQ;
`endif
      end
    end else begin
      m_phase++;
      if (m_phase == F + 4) m_active = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [NREQ-1:0] e_ack;
    logic [7:0]      e_data;
    e_ack  = (m_active && m_phase == 1) ? (NREQ'(1) << m_id) : '0;
    e_data = (m_active && m_phase >= 1 && m_phase <= 3) ? m_byte : 8'h00;
    chk("model_ack", 32'(ack), 32'(e_ack));
    chk("model_load", 32'(Load_XMT_datareg), 32'(m_active && m_phase == 1));
    chk("model_byte_ready", 32'(Byte_ready), 32'(m_active && m_phase == 2));
    chk("model_t_byte", 32'(T_byte), 32'(m_active && m_phase == 3));
    chk("model_data_bus", 32'(Data_Bus), 32'(e_data));
    chk("model_busy", 32'(busy), 32'(m_active));
    if (m_active) chk("model_grant_id", 32'(grant_id), 32'(m_id));
  endtask

  task automatic tick();
    @(negedge Clock);
    cmp_model();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"}, 32'(ack), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_grant_id"}, 32'(grant_id), 32'h0);
    chk({nm, "_data_bus"}, 32'(Data_Bus), 32'h0);
    chk({nm, "_strobes"}, 32'({Load_XMT_datareg, Byte_ready, T_byte}), 32'h0);
  endtask

  initial begin
    int gid[5];
    int gcyc[5];
    int ng;
    int first;
    int seen_gid;
    int seen_data;
    int n_ack3;
    int n_tb;
    int tb_data;

    rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single request from requester 1.
    req = 4'b0010;
    req_data = 32'h0000_A500;
    tick();
    chk("single_ack", 32'(ack), 32'h2);
    chk("single_load", 32'(Load_XMT_datareg), 32'h1);
    chk("single_data_load", 32'(Data_Bus), 32'hA5);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_gid", 32'(grant_id), 32'h1);
    req = '0;
    tick();
    chk("single_byte_ready", 32'(Byte_ready), 32'h1);
    chk("single_data_ready", 32'(Data_Bus), 32'hA5);
    tick();
    chk("single_t_byte", 32'(T_byte), 32'h1);
    chk("single_data_send", 32'(Data_Bus), 32'hA5);
    for (int k = 0; k < F; k++) begin
      tick();
      chk("single_wait_busy", 32'(busy), 32'h1);
      chk("single_wait_data", 32'(Data_Bus), 32'h0);
    end
    tick();
    chk("single_busy_drop", 32'(busy), 32'h0);

    // All requesters continuously active.
    reset_pulse();
    tick();
    req = 4'hF;
    req_data = {$urandom};
    ng = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (Load_XMT_datareg && ng < 5) begin
        gid[ng]  = int'(grant_id);
        gcyc[ng] = k;
        ng++;
      end
    end
    req = '0;
    chk("cont_grant_count", 32'(ng), 32'd5);
    for (int g = 0; g < 5 && g < ng; g++) begin
`ifdef UART_XMT_ARB_RR_EN
      chk("cont_grant_order", 32'(gid[g]), 32'(g % NREQ));
`else
      chk("cont_grant_order", 32'(gid[g]), 32'd0);
`endif
      if (g > 0) chk("cont_grant_spacing", 32'(gcyc[g] - gcyc[g-1]), 32'(F + 4));
    end
    repeat (20) tick();

    // Request raised during the wait window.
    req = 4'b0001;
    req_data = 32'h0000_0011;
    tick();
    chk("late_first_ack", 32'(ack), 32'h1);
    req = '0;
    repeat (5) tick();
    req = 4'b0100;
    req_data = 32'h003C_0000;
    first = -1;
    seen_gid = -1;
    seen_data = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (ack != '0 && first < 0) begin
        first     = k;
        seen_gid  = int'(grant_id);
        seen_data = int'(Data_Bus);
        req       = '0;
      end
    end
    chk("late_ack_delay", 32'(first), 32'd11);
    chk("late_gid", 32'(seen_gid), 32'd2);
    chk("late_data", 32'(seen_data), 32'h3C);
    req = '0;
    repeat (5) tick();

    // Reset pulsed while the frame is in READY.
    req = 4'b0010;
    req_data = 32'h0000_A100;
    tick();
    req = '0;
    tick();
    chk("abort_in_ready", 32'(Byte_ready), 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("abort_async");
    tick();
    rst = 1'b0;
    n_tb = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (T_byte) n_tb++;
    end
    chk("abort_no_t_byte", 32'(n_tb), 32'd0);
    req = 4'b0011;
    req_data = 32'h0000_7766;
    tick();
    chk("abort_next_gid", 32'(grant_id), 32'd0);
    chk("abort_next_ack", 32'(ack), 32'h1);
    req = '0;
    repeat (20) tick();

    // Requester 3 holds req for a single cycle.
    req = 4'b1000;
    req_data = 32'h5E00_0000;
    tick();
    n_ack3  = ack[3] ? 1 : 0;
    n_tb    = 0;
    tb_data = -1;
    req = '0;
    for (int k = 0; k < 19; k++) begin
      tick();
      if (ack[3]) n_ack3++;
      if (T_byte) begin
        n_tb++;
        tb_data = int'(Data_Bus);
      end
    end
    chk("drop_ack3_count", 32'(n_ack3), 32'd1);
    chk("drop_t_byte_count", 32'(n_tb), 32'd1);
    chk("drop_data", 32'(tb_data), 32'h5E);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_xmt_arbiter.md
UART_XMT_ARBITER -- requirements
Module: uart_xmt_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of byte requesters; legal range 2..8.
REQ-002 The block SHALL have parameter FRAME_CYCLES, default 12: cycles in the post-send wait window; legal range 10..255.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester byte request; held until ack.
REQ-007 The block SHALL have port req_data, input, 8*NREQ bits: byte i at [8i+7:8i]; held stable while req[i]=1.
REQ-008 The block SHALL have port ack, output, NREQ bits: one-cycle pulse when the granted byte is loaded.
REQ-009 The block SHALL have port grant_id, output, clog2(NREQ) bits: index of the current owner; valid while busy=1.
REQ-010 The block SHALL have port busy, output, 1 bit: high from grant until the end of the wait window.
REQ-011 The block SHALL have port Data_Bus, output, 8 bits: byte to the transmitter data register.
REQ-012 The block SHALL have port Load_XMT_datareg, output, 1 bit: transmitter data-register load strobe.
REQ-013 The block SHALL have port Byte_ready, output, 1 bit: transmitter byte-ready strobe.
REQ-014 The block SHALL have port T_byte, output, 1 bit: transmitter start-transmission strobe.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, READY, SEND and WAIT; all outputs SHALL be registered.
REQ-016 In IDLE with req!=0, the arbiter SHALL choose a winner per REQ-030/031, latch req_data of the winner into the byte register, set grant_id, set busy=1 and go to LOAD; with req==0 it SHALL stay in IDLE.
REQ-017 In LOAD (1 cycle), the block SHALL drive Load_XMT_datareg=1 and ack[grant_id]=1, then go to READY.
REQ-018 In READY (1 cycle), the block SHALL drive Byte_ready=1, then go to SEND.
REQ-019 In SEND (1 cycle), the block SHALL drive T_byte=1, then go to WAIT and load the frame counter with FRAME_CYCLES-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at 0, busy SHALL drop and the FSM SHALL go to IDLE. The wait SHALL last exactly FRAME_CYCLES cycles.
REQ-021 Data_Bus SHALL hold the latched byte from LOAD through SEND, and SHALL be 8'h00 otherwise.
REQ-022 The grant-to-grant minimum SHALL be FRAME_CYCLES+4 cycles (IDLE+LOAD+READY+SEND+WAIT).
REQ-023 At most one strobe among Load_XMT_datareg, Byte_ready, T_byte and at most one ack bit SHALL be high in any cycle.
REQ-024 The byte latched at grant SHALL be sent even if the requester drops req after the grant.
REQ-025 req SHALL be sampled only in IDLE; requests raised during LOAD..WAIT SHALL wait for the next IDLE.
REQ-026 The frame counter SHALL be 8 bits, with no wrap: it SHALL reload only in SEND.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE; ack, busy, grant_id, Data_Bus, the three strobes, the counter and the byte register SHALL all be 0.
REQ-028 rst asserted mid-frame SHALL abort immediately: the strobes SHALL fall without completing the sequence, and no ack SHALL be issued for the aborted grant unless LOAD had already occurred.
REQ-029 After reset, the round-robin pointer SHALL be 0, so req[0] has highest priority.

Configuration
REQ-030 With UART_XMT_ARB_RR_EN defined, the arbiter SHALL be round-robin: search starts at last_grant+1 modulo NREQ, and the pointer SHALL update on each grant.
REQ-031 Without UART_XMT_ARB_RR_EN, the arbiter SHALL use fixed priority with the lowest index winning; no pointer register SHALL exist.

Verification
REQ-032 Single request: req=4'b0010, data1=8'hA5 -> ack[1] and Load_XMT_datareg both high at grant+1, Byte_ready at grant+2, T_byte at grant+3, Data_Bus=8'hA5 over those 3 cycles, busy low after 12 WAIT cycles.
REQ-033 All four requesting continuously with RR_EN: grants SHALL be 0,1,2,3,0 at 16-cycle spacing. Without RR_EN: grants SHALL be 0,0,0 until req[0] drops.
REQ-034 Request arrives during WAIT: req[2] raised in WAIT cycle 3 -> no ack until the next IDLE, then grant_id=2.
REQ-035 Reset mid-frame: rst pulsed in READY -> all outputs 0 asynchronously, no T_byte, and the next grant follows reset priority.
REQ-036 Requester drops req after grant: req[3] held one cycle only -> the byte is still sent with T_byte pulsed once, and ack[3] pulses once.
